// File: rtl/ibex_rvfi_trace_buffer_pkg.sv
// Types shared by the RVFI retirement trace buffer and its storage array.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ibex_rvfi_trace_buffer_pkg;

  // Width of the rvfi_order slice kept in each stored record
  localparam int unsigned TraceOrderW = 16;

  typedef enum logic [1:0] {
    TraceFifo    = 2'b00,
    TraceRing    = 2'b01,
    TraceTrigger = 2'b10
  } trace_mode_e;

  typedef enum logic [1:0] {
    TrIdle,
    TrCapture,
    TrPost,
    TrFrozen
  } trace_state_e;

  typedef struct packed {
    logic [TraceOrderW-1:0] order;
    logic [31:0]            pc;
    logic [31:0]            insn;
    logic [31:0]            rd_wdata;
    logic [4:0]             rd_addr;
    logic                   trap;
    logic                   intr;
  } trace_rec_t;

  // Ring and trigger modes replace the oldest record when full; FIFO and the
  // reserved encoding drop the incoming record instead.
  function automatic logic mode_overwrites(input logic [1:0] mode);
    return (mode == TraceRing) || (mode == TraceTrigger);
  endfunction

endpackage

// File: rtl/ibex_trace_ram.sv
// Flop-based record store: one write port, one asynchronous read port.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; the caller owns pointer and occupancy bookkeeping.
module ibex_trace_ram
  import ibex_rvfi_trace_buffer_pkg::*;
#(
  parameter int unsigned Depth = 16,
  localparam int unsigned AW   = $clog2(Depth)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  trace_rec_t    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output trace_rec_t    rdata_o
);

  // Storage is deliberately not reset; the read side masks empty entries.
  trace_rec_t mem [Depth];

  // Single write port
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/ibex_rvfi_trace_buffer.sv
// Captures RVFI retirements into a circular buffer (FIFO, ring or triggered snapshot).
// Latency: a record written on edge N is readable on rd_data_o from cycle N+1.
// Backpressure: rd_valid_o/rd_ready_i on read; full FIFO drops, ring/trigger overwrite.
module ibex_rvfi_trace_buffer
  import ibex_rvfi_trace_buffer_pkg::*;
#(
  parameter int unsigned Depth      = 16,
  parameter int unsigned OrderW     = 16,
  parameter logic        TrigOnTrap = 1'b1,
  parameter int unsigned DropCntW   = 16,
  localparam int unsigned AW        = $clog2(Depth),
  localparam int unsigned CW        = AW + 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                rvfi_valid,
  input  logic [63:0]         rvfi_order,
  input  logic [31:0]         rvfi_pc_rdata,
  input  logic [31:0]         rvfi_insn,
  input  logic                rvfi_trap,
  input  logic                rvfi_intr,
  input  logic [4:0]          rvfi_rd_addr,
  input  logic [31:0]         rvfi_rd_wdata,
  input  logic                arm_i,
  input  logic                disarm_i,
  input  logic [1:0]          mode_i,
  input  logic [31:0]         trig_pc_i,
  input  logic [CW-1:0]       post_cnt_i,
  output logic                rd_valid_o,
  input  logic                rd_ready_i,
  output trace_rec_t          rd_data_o,
  output logic [CW-1:0]       count_o,
  output logic                triggered_o,
  output logic                frozen_o,
  output logic                overflow_o,
  output logic [DropCntW-1:0] drop_cnt_o
);

  trace_state_e        state_q, state_d;
  logic [1:0]          mode_q;
  logic [31:0]         trig_pc_q;
  logic [CW-1:0]       post_rem_q;
  logic [AW-1:0]       wptr_q, rptr_q;
  logic [CW-1:0]       count_q;
  logic                triggered_q, overflow_q;
  logic [DropCntW-1:0] drop_cnt_q;

  trace_rec_t wr_rec, ram_rdata;
  logic       capturing, full, pop, ovw_mode;
  logic       wr_req, wr_en, rd_adv, drop_evt, trig_hit;
  logic       unused_order_hi;

  assign unused_order_hi = ^rvfi_order[63:OrderW];

  assign wr_rec = '{
    order:    rvfi_order[OrderW-1:0],
    pc:       rvfi_pc_rdata,
    insn:     rvfi_insn,
    rd_wdata: rvfi_rd_wdata,
    rd_addr:  rvfi_rd_addr,
    trap:     rvfi_trap,
    intr:     rvfi_intr
  };

  assign capturing = (state_q == TrCapture) || (state_q == TrPost);
  assign full      = (count_q == CW'(Depth));
  assign rd_valid_o = (count_q != '0);
  assign pop       = rd_valid_o && rd_ready_i;
  assign ovw_mode  = mode_overwrites(mode_q);

  // arm_i discards any same-cycle retirement.
  assign wr_req   = rvfi_valid && capturing && !arm_i;
  assign wr_en    = wr_req && (!full || pop || ovw_mode);
  assign drop_evt = wr_req && full && !pop;
  // Read pointer moves on a pop, or when an overwrite evicts the oldest record.
  assign rd_adv   = pop || (drop_evt && ovw_mode);

  assign trig_hit = (state_q == TrCapture) && rvfi_valid && (mode_q == TraceTrigger) &&
                    ((rvfi_pc_rdata == trig_pc_q) || (TrigOnTrap && rvfi_trap));

  ibex_trace_ram #(
    .Depth (Depth)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (wr_en),
    .waddr_i (wptr_q),
    .wdata_i (wr_rec),
    .raddr_i (rptr_q),
    .rdata_o (ram_rdata)
  );

  // Mask the unreset array so an empty buffer always presents zero.
  assign rd_data_o   = rd_valid_o ? ram_rdata : '0;
  assign count_o     = count_q;
  assign triggered_o = triggered_q;
  assign frozen_o    = (state_q == TrFrozen);
  assign overflow_o  = overflow_q;
  assign drop_cnt_o  = drop_cnt_q;

  // Capture state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= TrIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: trigger/post progression, then disarm, then arm (highest priority)
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TrCapture: if (trig_hit) state_d = (post_rem_q == '0) ? TrFrozen : TrPost;
      TrPost:    if (wr_en && (post_rem_q == CW'(1))) state_d = TrFrozen;
      default:   ;
    endcase
    if (disarm_i) state_d = TrIdle;
    if (arm_i)    state_d = TrCapture;
  end

  // Pointers, occupancy, configuration latch and status flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q      <= TraceFifo;
      trig_pc_q   <= '0;
      post_rem_q  <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      triggered_q <= 1'b0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else if (arm_i) begin
      mode_q      <= mode_i;
      trig_pc_q   <= trig_pc_i;
      post_rem_q  <= post_cnt_i;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      triggered_q <= 1'b0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      if (wr_en)  wptr_q <= wptr_q + 1'b1;
      if (rd_adv) rptr_q <= rptr_q + 1'b1;
      if (wr_en && !rd_adv)      count_q <= count_q + 1'b1;
      else if (!wr_en && rd_adv) count_q <= count_q - 1'b1;
      if (trig_hit) triggered_q <= 1'b1;
      if ((state_q == TrPost) && wr_en) post_rem_q <= post_rem_q - 1'b1;
      if (drop_evt) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: doc/ibex_rvfi_trace_buffer.md
Name: ibex_rvfi_trace_buffer

Overview:
On-chip retirement trace capture for the Ibex core, fed by the RVFI retirement port and instantiated beside the core in the tracing top level. Unlike the simulation-only text tracer, it stores compact retirement records in a synthesizable circular buffer. It supports lossless-FIFO, overwrite-ring and PC/trap-triggered snapshot modes, and records are read out over a valid/ready port.

Parameters:
Depth, 16, buffer entries; power of two, >=2
OrderW, 16, low bits of rvfi_order stored per record
TrigOnTrap, 1'b1, a retired trap (rvfi_trap) also fires the trigger in trigger mode
DropCntW, 16, width of the saturating dropped-record counter

Ports:
clk_i  in  1  clock
rst_ni  in  1  async reset, active low
rvfi_valid  in  1  retirement strobe
rvfi_order  in  64  retirement index
rvfi_pc_rdata  in  32  retired PC
rvfi_insn  in  32  instruction word
rvfi_trap  in  1  trapped retirement
rvfi_intr  in  1  first instruction of a handler
rvfi_rd_addr  in  5  destination register
rvfi_rd_wdata  in  32  destination write data
arm_i  in  1  pulse: flush buffer, latch config, enter CAPTURE
disarm_i  in  1  pulse: stop capture, keep contents
mode_i  in  2  trace_mode_e; latched on arm_i
trig_pc_i  in  32  trigger PC; latched on arm_i
post_cnt_i  in  $clog2(Depth)+1  records captured after the trigger record; latched on arm_i
rd_valid_o  out  1  record available
rd_ready_i  in  1  pop when rd_valid_o
rd_data_o  out  trace_rec_t  oldest record
count_o  out  $clog2(Depth)+1  occupancy
triggered_o  out  1  trigger has fired since the last arm
frozen_o  out  1  state == FROZEN
overflow_o  out  1  sticky: a record was dropped (FIFO) or overwritten (ring)
drop_cnt_o  out  DropCntW  saturating count of dropped or overwritten records

Behaviour:
- One clock, clk_i. Reset is asynchronous, active-low rst_ni. At reset: state IDLE, pointers 0, count_o 0, rd_valid_o 0, rd_data_o 0, triggered_o 0, frozen_o 0, overflow_o 0, drop_cnt_o 0, latched mode TraceFifo.
- Record: {order[OrderW-1:0], pc, insn, rd_wdata, rd_addr, trap, intr}, packed into trace_rec_t.
- A record is written only when rvfi_valid=1 and the state is CAPTURE or POST. No bypass: the record is visible on rd_data_o no earlier than the cycle after its write.
- rd_valid_o = (count != 0). rd_data_o is the entry at the read pointer. A pop (rd_valid_o & rd_ready_i) advances the read pointer. Reads are allowed in every state. rd_data_o is held stable while rd_valid_o=1 and rd_ready_i=0, unless a ring overwrite advances the read pointer.
- Pointers are $clog2(Depth) bits wide and wrap naturally. count is an explicit counter.
- States and transitions:
  - IDLE -arm-> CAPTURE.
  - CAPTURE -trigger (mode TraceTrigger only)-> POST, or -> FROZEN if the latched post count is 0.
  - POST -last post record written-> FROZEN.
  - Any state -disarm-> IDLE.
  - Any state -arm-> CAPTURE.
- arm_i flushes the buffer: pointers 0, count 0, triggered_o 0, overflow_o 0, drop_cnt_o 0. arm_i has priority over disarm_i and over a same-cycle write; that write is discarded.
- Trigger: in CAPTURE with rvfi_valid and (pc == trig_pc, or TrigOnTrap & rvfi_trap). The trigger record is itself written. The post counter loads post_cnt and decrements on each record written in POST.
- Full buffer, TraceFifo: a write with no same-cycle pop is dropped, sets overflow_o and increments drop_cnt_o. A write with a same-cycle pop is accepted and count is unchanged.
- Full buffer, TraceRing or TraceTrigger: a write with no pop overwrites the oldest entry, advances the read pointer, and sets overflow_o and drop_cnt_o (counts overwrites). A write with a same-cycle pop is a normal push plus pop.
- Empty buffer with a simultaneous write and pop request: the pop is ignored and the write is taken.
- mode_i value 2'b11 is reserved and behaves as TraceFifo.
- drop_cnt_o saturates at all ones.

Decomposition:
- ibex_pkg additions:
  - trace_mode_e {TraceFifo=2'b00, TraceRing=2'b01, TraceTrigger=2'b10}
  - trace_state_e {TrIdle, TrCapture, TrPost, TrFrozen}
  - trace_rec_t, with the order field width set by a package constant TraceOrderW=16
- One sub-module, ibex_trace_ram: Depth x $bits(trace_rec_t), one write port and one asynchronous read port, flop-based, no reset on the storage array.

Test Plan:
1. Reset mid-capture with 5 records stored → next cycle count_o=0, rd_valid_o=0, state IDLE; rvfi_valid ignored until arm_i.
2. Depth=16, TraceFifo, arm, 20 retirements with no reads → count_o=16, overflow_o=1, drop_cnt_o=4; reads return order 0..15 in sequence.
3. TraceRing, arm, 20 retirements with no reads → count_o=16, drop_cnt_o=4; reads return order 4..19.
4. TraceTrigger with trig_pc=32'h0000_0100 and post_cnt=3; retirements with order 0..29, PC 0x100 at order 10 → triggered_o at order 10, frozen_o after order 13 is written; buffer holds orders 0..13, and later retirements are ignored.
5. Full FIFO, rd_ready_i held at 1, one retirement per cycle for 10 cycles → no drops, count_o stays at 16, overflow_o=0.
6. Trigger mode with TrigOnTrap=1, post_cnt=0, rvfi_trap=1 at order 7 → FROZEN the next cycle; the last record read has trap=1 and order 7. arm_i and disarm_i asserted together → flush, CAPTURE.
